// File: rtl/uart_rx_sampler_pkg.sv
// uart_rx_pkg: shared widths, legal prescale values, frame lengths and sample-point helper
package uart_rx_pkg;
  localparam int DEF_PRESCALE_W = 6;
  localparam int DEF_BIT_CNT_W = 4;
  localparam int PRESC_8 = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;
  localparam int FRAME_BITS_NOPAR = 10;
  localparam int FRAME_BITS_PAR = 11;
  function automatic int unsigned mid_point(input int unsigned prescale);
    return prescale >> 1;
  endfunction
endpackage

// File: rtl/uart_rx_sampler_if.sv
// uart_rx_sampler_if: line, controls and sampler results shared between receive FSM and sampler
interface uart_rx_sampler_if
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int BIT_CNT_W = DEF_BIT_CNT_W
);
  logic RX_IN;
  logic [PRESCALE_W-1:0] prescale;
  logic enable;
  logic data_sample_enable;
  logic reset_counters;
  logic rx_sync;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [BIT_CNT_W-1:0] bit_cnt;
  logic sampled_bit;
  logic sample_valid;
  modport master (
    output RX_IN, prescale, enable, data_sample_enable, reset_counters,
    input rx_sync, edge_cnt, bit_cnt, sampled_bit, sample_valid
  );
  modport slave (
    input RX_IN, prescale, enable, data_sample_enable, reset_counters,
    output rx_sync, edge_cnt, bit_cnt, sampled_bit, sample_valid
  );
endinterface

// File: rtl/uart_rx_sampler_edge_bit_counter.sv
// uart_rx_edge_bit_counter: oversample tick counter with wrap and saturating bit counter
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
#(
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int BIT_CNT_W = DEF_BIT_CNT_W
) (
  input  logic CLK,
  input  logic RST,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic enable,
  input  logic reset_counters,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0] bit_cnt
);
  logic wrap;
  assign wrap = edge_cnt >= prescale - PRESCALE_W'(1);
  always_ff @(posedge CLK) begin
    if (RST || reset_counters) begin
      edge_cnt <= '0;
      bit_cnt <= '0;
    end else if (enable) begin
      edge_cnt <= wrap ? '0 : edge_cnt + PRESCALE_W'(1);
      if (wrap && bit_cnt != '1) bit_cnt <= bit_cnt + BIT_CNT_W'(1);
    end
  end
endmodule

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: RX_IN synchroniser, edge/bit counters and 3-sample majority voter
module uart_rx_sampler
  import uart_rx_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int PRESCALE_W = DEF_PRESCALE_W,
  parameter int BIT_CNT_W = DEF_BIT_CNT_W
) (
  input logic CLK,
  input logic RST,
  uart_rx_sampler_if.slave rx
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [PRESCALE_W-1:0] half;
  logic [2:0] samp;
  logic [1:0] n;
  logic cap, at0, at1, at2, vote, bit_q;
  always_ff @(posedge CLK) begin
    if (RST) sync_q <= '1;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], rx.RX_IN};
  end
  assign rx.rx_sync = sync_q[SYNC_STAGES-1];
  uart_rx_edge_bit_counter #(.PRESCALE_W(PRESCALE_W), .BIT_CNT_W(BIT_CNT_W)) u_cnt (
    .CLK(CLK),
    .RST(RST),
    .prescale(rx.prescale),
    .enable(rx.enable),
    .reset_counters(rx.reset_counters),
    .edge_cnt(rx.edge_cnt),
    .bit_cnt(rx.bit_cnt)
  );
  assign half = PRESCALE_W'(mid_point(32'(rx.prescale)));
  assign cap = rx.enable && rx.data_sample_enable && !rx.reset_counters;
  assign at0 = cap && rx.edge_cnt == half - PRESCALE_W'(2);
  assign at1 = cap && rx.edge_cnt == half - PRESCALE_W'(1);
  assign at2 = cap && rx.edge_cnt == half;
  assign vote = at2 && n == 2'd2;
  always_ff @(posedge CLK) begin
    if (RST) begin
      samp <= 3'b111;
      n <= '0;
      rx.sample_valid <= 1'b0;
      bit_q <= 1'b1;
    end else begin
      rx.sample_valid <= vote;
      bit_q <= rx.sampled_bit;
      if (rx.reset_counters || (rx.edge_cnt == '0 && !at0)) begin
        samp <= 3'b111;
        n <= '0;
      end else if (at0 || at1 || at2) begin
        samp <= {samp[1:0], rx.rx_sync};
        n <= at0 ? 2'd1 : (at1 && n == 2'd1) ? 2'd2 : 2'd0;
      end
    end
  end
  assign rx.sampled_bit = rx.sample_valid ? (samp[0] & samp[1]) | (samp[0] & samp[2]) | (samp[1] & samp[2]) : bit_q;
endmodule
